// File: rtl/dram_lane_model.sv
// dram_lane_model: behavioural multi-lane byte-wide DRAM with a fixed access latency.
//
// All enabled lanes issue one request together and share a single read/write command and
// one timing FSM. Every lane has its own address and data. Completion is a one-cycle
// per-lane valid pulse that appears LATENCY edges after the capture edge.
//
// Ports:
//   clk      in   clock; all logic is on the rising edge
//   reset    in   synchronous, active-high reset
//   en       in   [NUM_PORTS]           per-lane request enable
//   rdwr     in   shared command: 0 = write, 1 = read
//   data_in  in   [NUM_PORTS][DATA_W]   write data per lane
//   addr     in   [NUM_PORTS][ADDR_W]   byte address per lane; bits above MEM_ADDR_BITS ignored
//   data_out out  [NUM_PORTS][DATA_W]   registered read data; holds between completions
//   valid    out  [NUM_PORTS]           registered per-lane completion pulse
//
// Optional feature macro: DRAM_CLEAR_ON_RESET_EN
//   When defined, every memory word is cleared to 0 while reset is high. When not defined,
//   memory contents persist across reset and unwritten words read X in simulation.
module dram_lane_model #(
  parameter int unsigned NUM_PORTS     = 8,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned ADDR_W        = 64,
  parameter int unsigned MEM_ADDR_BITS = 10,
  parameter int unsigned LATENCY       = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_PORTS-1:0]               en,
  input  logic                               rdwr,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]   data_in,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]   addr,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]   data_out,
  output logic [NUM_PORTS-1:0]               valid
);

  localparam int unsigned Depth   = 2 ** MEM_ADDR_BITS;
  localparam int unsigned CntW    = $clog2(LATENCY) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            capture;
  logic            access;

  // Request captured at the IDLE->BUSY edge; inputs are ignored while BUSY.
  logic [NUM_PORTS-1:0]                      mask_q;
  logic                                      rdwr_q;
  logic [NUM_PORTS-1:0][MEM_ADDR_BITS-1:0]   addr_q;
  logic [NUM_PORTS-1:0][DATA_W-1:0]          data_q;

  logic [DATA_W-1:0] mem [Depth];

  // Upper address bits are deliberately dropped so addresses wrap modulo the depth.
  logic unused_addr_hi;
  always_comb begin
    unused_addr_hi = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      unused_addr_hi = unused_addr_hi ^ (^addr[i][ADDR_W-1:MEM_ADDR_BITS]);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|en) begin
          capture = 1'b1;
          state_d = StBusy;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        if (cnt_q == CntLast) begin
          access  = 1'b1;
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state, capture registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      valid    <= '0;
      data_out <= '0;
      mask_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid   <= access ? mask_q : '0;
      if (capture) begin
        mask_q <= en;
        rdwr_q <= rdwr;
        data_q <= data_in;
        for (int i = 0; i < NUM_PORTS; i++) begin
          addr_q[i] <= addr[i][MEM_ADDR_BITS-1:0];
        end
      end
      if (access && rdwr_q) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (mask_q[i]) begin
            data_out[i] <= mem[addr_q[i]];
          end
        end
      end
    end
  end

  // Memory array. Lanes are written in ascending order, so on a same-word collision the
  // highest lane index is the last assignment and wins.
  always_ff @(posedge clk) begin
`ifdef DRAM_CLEAR_ON_RESET_EN
    if (reset) begin
      for (int j = 0; j < Depth; j++) begin
        mem[j] <= '0;
      end
    end else if (access && !rdwr_q) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (mask_q[i]) begin
          mem[addr_q[i]] <= data_q[i];
        end
      end
    end
`else
    if (!reset && access && !rdwr_q) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (mask_q[i]) begin
          mem[addr_q[i]] <= data_q[i];
        end
      end
    end
`endif
  end

endmodule

// File: tb/tb_dram_lane_model.sv
// Directed bench for dram_lane_model with its default parameters (LATENCY = 8).
module tb_dram_lane_model;

  logic                 clk;
  logic                 reset;
  logic [7:0]           en;
  logic                 rdwr;
  logic [7:0][7:0]      data_in;
  logic [7:0][63:0]     addr;
  logic [7:0][7:0]      data_out;
  logic [7:0]           valid;

  int total = 0;
  int bad   = 0;

  dram_lane_model dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .rdwr     (rdwr),
    .data_in  (data_in),
    .addr     (addr),
    .data_out (data_out),
    .valid    (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE at a negedge; capture happens on the next posedge (E0).
  // valid must show on the 9th negedge after E0 (i.e. after edge E0+8) and clear one later.
  task automatic run_req(input logic [7:0] m, input logic rw, input string tag);
    int n;
    en   = m;
    rdwr = rw;
    @(negedge clk);
    en = '0;
    n  = 1;
    while (valid === 8'h00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd9);
    check({tag, "_valid"}, 64'(valid), 64'(m));
    @(negedge clk);
    check({tag, "_vclr"}, 64'(valid), 64'd0);
  endtask

  logic [7:0][7:0] exp_v;
  int              pt   [4];
  logic [7:0]      pd   [4];
  int              pulses;
  int              n;
  int              vcount;

  initial begin
    reset   = 1'b1;
    en      = '0;
    rdwr    = 1'b0;
    data_in = '0;
    addr    = '0;

    // Reset, then idle with en=0
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_valid", 64'(valid), 64'd0);
    check("idle_dout", 64'(data_out), 64'd0);
    check("idle_state", 64'(dut.state_q), 64'd0);

    // Basic write then read, lane 0
    addr[0] = 64'd0; data_in[0] = 8'h01;
    run_req(8'h01, 1'b0, "wr0");
    check("wr0_dout_hold", 64'(data_out), 64'd0);
    data_in[0] = 8'hFF;
    run_req(8'h01, 1'b1, "rd0");
    check("rd0_data", 64'(data_out[0]), 64'h01);

    // Preload addr 9 and 10 for the steady-repeat test
    addr[0] = 64'd9;  data_in[0] = 8'h5A;
    addr[1] = 64'd10; data_in[1] = 8'h6B;
    run_req(8'h03, 1'b0, "wr_pre");

    // Steady repeat with en held: first capture reads addr 9, addr moved to 10 during BUSY
    addr = '0; addr[0] = 64'd9;
    en = 8'h01; rdwr = 1'b1;
    @(negedge clk);
    addr[0] = 64'd10;
    n = 1; pulses = 0;
    while (n < 31) begin
      @(negedge clk);
      n++;
      if (n == 25) en = '0;
      if (valid !== 8'h00) begin
        if (pulses < 4) begin
          pt[pulses] = n;
          pd[pulses] = data_out[0];
        end
        pulses++;
      end
    end
    check("rep_count", 64'(pulses), 64'd3);
    check("rep_t0", 64'(pt[0]), 64'd9);
    check("rep_t1", 64'(pt[1]), 64'd19);
    check("rep_t2", 64'(pt[2]), 64'd29);
    check("rep_d0", 64'(pd[0]), 64'h5A);
    check("rep_d1", 64'(pd[1]), 64'h6B);
    check("rep_d2", 64'(pd[2]), 64'h6B);

    // All lanes write addr i with A0+i, then read back
    for (int i = 0; i < 8; i++) begin
      addr[i]    = 64'(i);
      data_in[i] = 8'hA0 + 8'(i);
      exp_v[i]   = 8'hA0 + 8'(i);
    end
    run_req(8'hFF, 1'b0, "wr_all");
    data_in = '0;
    run_req(8'hFF, 1'b1, "rd_all");
    check("rd_all_data", 64'(data_out), 64'(exp_v));

    // Write collision: lanes 2 and 5 to addr 7, highest lane wins
    addr[2] = 64'd7; data_in[2] = 8'h22;
    addr[5] = 64'd7; data_in[5] = 8'h55;
    run_req(8'h24, 1'b0, "wr_coll");
    for (int i = 0; i < 8; i++) addr[i] = 64'd7;
    run_req(8'hFF, 1'b1, "rd_coll");
    check("rd_coll_data", 64'(data_out), {8{8'h55}});

    // Partial read: lane 0 only, other lanes keep their previous data
    addr[0] = 64'd3;
    run_req(8'h01, 1'b1, "rd_part");
    check("rd_part_data", 64'(data_out), {{7{8'h55}}, 8'hA3});

    // Address wrap: 0x400 aliases word 0
    addr = '0; data_in = '0;
    addr[0] = 64'h400; data_in[0] = 8'h3C;
    run_req(8'h01, 1'b0, "wr_wrap");
    addr[0] = 64'h0;
    run_req(8'h01, 1'b1, "rd_wrap");
    check("rd_wrap_data", 64'(data_out[0]), 64'h3C);

    // Reset in the middle of a write of EE to addr 5 (holds A5)
    addr[0] = 64'd5; data_in[0] = 8'hEE;
    en = 8'h01; rdwr = 1'b0;
    @(negedge clk);
    en = '0;
    repeat (4) @(negedge clk);
    check("mid_cnt", 64'(dut.cnt_q), 64'd4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_state", 64'(dut.state_q), 64'd0);
    vcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid !== 8'h00) vcount++;
    end
    check("mid_novalid", 64'(vcount), 64'd0);
    check("mid_dout_rst", 64'(data_out), 64'd0);
    data_in[0] = 8'h00;
    run_req(8'h01, 1'b1, "rd_mid");
`ifdef DRAM_CLEAR_ON_RESET_EN
    check("rd_mid_data", 64'(data_out[0]), 64'h00);
`else
    check("rd_mid_data", 64'(data_out[0]), 64'hA5);
`endif

    // Memory across reset
    addr[0] = 64'd3; data_in[0] = 8'h77;
    run_req(8'h01, 1'b0, "wr_77");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_req(8'h01, 1'b1, "rd_77");
`ifdef DRAM_CLEAR_ON_RESET_EN
    check("rd_77_data", 64'(data_out[0]), 64'h00);
`else
    check("rd_77_data", 64'(data_out[0]), 64'h77);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
